// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU, branch resolution, registered compare flags,
// and a 32-step restoring signed divider that stalls the pipeline while it runs.
module execute_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        validE,
    input  logic [31:0] PCE,
    input  logic [31:0] branchTargetE,
    input  logic [31:0] immxE,
    input  logic [31:0] op1E,
    input  logic [31:0] op2E,
    input  logic        isImmediateE,
    input  logic        isStE,
    input  logic        isLdE,
    input  logic        isBeqE,
    input  logic        isBgtE,
    input  logic        isRetE,
    input  logic        isUbranchE,
    input  logic        isCallE,
    input  logic        isAddE,
    input  logic        isSubE,
    input  logic        isCmpE,
    input  logic        isMulE,
    input  logic        isDivE,
    input  logic        isModE,
    input  logic        isLslE,
    input  logic        isLsrE,
    input  logic        isAsrE,
    input  logic        isOrE,
    input  logic        isAndE,
    input  logic        isNotE,
    input  logic        isMovE,
    output logic [31:0] aluResultE,
    output logic        isBranchTakenE,
    output logic [31:0] branchPCE,
    output logic        flagE,
    output logic        flagGT,
    output logic        stallEx
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsr_q, dsr_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
    logic        mod_q, mod_d;
    logic        flag_e_q, flag_e_d;
    logic        flag_gt_q, flag_gt_d;

    logic [31:0] op_a, op_b;
    logic [31:0] alu_comb;
    logic [31:0] div_res;
    logic [32:0] shifted, trial;
    logic        step_bit;
    logic        div_req;
    logic        cmp_en;

    assign op_a    = op1E;
    assign op_b    = isImmediateE ? immxE : op2E;
    assign div_req = validE & (isDivE | isModE);

    assign stallEx = ~reset & (((state_q == IDLE) & div_req) | (state_q == DIV));

    // Restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    assign shifted  = {rem_q, quo_q[31]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign step_bit = ~trial[32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        mod_d   = mod_q;
        case (state_q)
            IDLE: begin
                if (div_req) begin
                    state_d = DIV;
                    cnt_d   = 5'd0;
                    quo_d   = op_a[31] ? (32'd0 - op_a) : op_a;
                    rem_d   = 32'd0;
                    dsr_d   = op_b[31] ? (32'd0 - op_b) : op_b;
                    q_neg_d = op_a[31] ^ op_b[31];
                    r_neg_d = op_a[31];
                    dz_d    = (op_b == 32'd0);
                    mod_d   = isModE;
                end
            end
            DIV: begin
                rem_d = step_bit ? trial[31:0] : shifted[31:0];
                quo_d = {quo_q[30:0], step_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With a zero divisor the remainder path already yields the dividend; only the quotient is forced.
    always_comb begin
        div_res = 32'd0;
        if (mod_q) begin
            div_res = r_neg_q ? (32'd0 - rem_q) : rem_q;
        end else if (dz_q) begin
            div_res = 32'hFFFF_FFFF;
        end else begin
            div_res = q_neg_q ? (32'd0 - quo_q) : quo_q;
        end
    end

    always_comb begin
        alu_comb = 32'd0;
        if (isLdE | isStE) begin
            alu_comb = op_a + op_b;
        end else if (isCallE) begin
            alu_comb = PCE + 32'd4;
        end else if (isAddE) begin
            alu_comb = op_a + op_b;
        end else if (isSubE) begin
            alu_comb = op_a - op_b;
        end else if (isMulE) begin
            alu_comb = op_a * op_b;
        end else if (isLslE) begin
            alu_comb = op_a << op_b[4:0];
        end else if (isLsrE) begin
            alu_comb = op_a >> op_b[4:0];
        end else if (isAsrE) begin
            alu_comb = $signed(op_a) >>> op_b[4:0];
        end else if (isOrE) begin
            alu_comb = op_a | op_b;
        end else if (isAndE) begin
            alu_comb = op_a & op_b;
        end else if (isNotE) begin
            alu_comb = ~op_b;
        end else if (isMovE) begin
            alu_comb = op_b;
        end
    end

    assign aluResultE = (state_q == DONE) ? div_res : alu_comb;

    assign isBranchTakenE = validE & ~stallEx &
                            (isUbranchE | (isBeqE & flag_e_q) | (isBgtE & flag_gt_q));
    assign branchPCE      = isRetE ? op1E : branchTargetE;

    assign cmp_en    = validE & isCmpE & ~stallEx;
    assign flag_e_d  = cmp_en ? (op_a == op_b) : flag_e_q;
    assign flag_gt_d = cmp_en ? ($signed(op_a) > $signed(op_b)) : flag_gt_q;

    assign flagE  = flag_e_q;
    assign flagGT = flag_gt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dsr_q     <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            mod_q     <= 1'b0;
            flag_e_q  <= 1'b0;
            flag_gt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            dz_q      <= dz_d;
            mod_q     <= mod_d;
            flag_e_q  <= flag_e_d;
            flag_gt_q <= flag_gt_d;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed corner cases plus random instructions,
// checked by a queue-based scoreboard against a behavioural model.
module tb_execute_unit;

    localparam int W = 73;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_MOD  = 4;
    localparam int OP_LSL  = 5;
    localparam int OP_LSR  = 6;
    localparam int OP_ASR  = 7;
    localparam int OP_OR   = 8;
    localparam int OP_AND  = 9;
    localparam int OP_NOT  = 10;
    localparam int OP_MOV  = 11;
    localparam int OP_CMP  = 12;
    localparam int OP_LD   = 13;
    localparam int OP_ST   = 14;
    localparam int OP_CALL = 15;
    localparam int OP_BEQ  = 16;
    localparam int OP_BGT  = 17;
    localparam int OP_UB   = 18;
    localparam int OP_RET  = 19;
    localparam int OP_NOP  = 20;
    localparam int NUM_OPS = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic        validE;
    logic [31:0] PCE, branchTargetE, immxE, op1E, op2E;
    logic        isImmediateE, isStE, isLdE, isBeqE, isBgtE, isRetE, isUbranchE, isCallE;
    logic        isAddE, isSubE, isCmpE, isMulE, isDivE, isModE, isLslE, isLsrE;
    logic        isAsrE, isOrE, isAndE, isNotE, isMovE;
    logic [31:0] aluResultE;
    logic        isBranchTakenE;
    logic [31:0] branchPCE;
    logic        flagE, flagGT, stallEx;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int stall_cnt = 0;
    logic m_fe = 1'b0;
    logic m_fg = 1'b0;

    always #5 clk = ~clk;

    execute_unit dut (
        .clk(clk), .reset(reset), .validE(validE), .PCE(PCE),
        .branchTargetE(branchTargetE), .immxE(immxE), .op1E(op1E), .op2E(op2E),
        .isImmediateE(isImmediateE), .isStE(isStE), .isLdE(isLdE), .isBeqE(isBeqE),
        .isBgtE(isBgtE), .isRetE(isRetE), .isUbranchE(isUbranchE), .isCallE(isCallE),
        .isAddE(isAddE), .isSubE(isSubE), .isCmpE(isCmpE), .isMulE(isMulE),
        .isDivE(isDivE), .isModE(isModE), .isLslE(isLslE), .isLsrE(isLsrE),
        .isAsrE(isAsrE), .isOrE(isOrE), .isAndE(isAndE), .isNotE(isNotE),
        .isMovE(isMovE), .aluResultE(aluResultE), .isBranchTakenE(isBranchTakenE),
        .branchPCE(branchPCE), .flagE(flagE), .flagGT(flagGT), .stallEx(stallEx)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] bb, input logic [31:0] pc);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = bb;
        case (op)
            OP_ADD, OP_LD, OP_ST: return a + bb;
            OP_SUB:  return a - bb;
            OP_MUL:  return a * bb;
            OP_DIV: begin
                if (bb == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && bb == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OP_MOD: begin
                if (bb == 32'd0) return a;
                if (a == 32'h8000_0000 && bb == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            OP_LSL:  return a << bb[4:0];
            OP_LSR:  return a >> bb[4:0];
            OP_ASR:  return sa >>> bb[4:0];
            OP_OR:   return a | bb;
            OP_AND:  return a & bb;
            OP_NOT:  return ~bb;
            OP_MOV:  return bb;
            OP_CALL: return pc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_ctrl(input int op);
        isAddE = (op == OP_ADD); isSubE = (op == OP_SUB); isMulE = (op == OP_MUL);
        isDivE = (op == OP_DIV); isModE = (op == OP_MOD); isLslE = (op == OP_LSL);
        isLsrE = (op == OP_LSR); isAsrE = (op == OP_ASR); isOrE = (op == OP_OR);
        isAndE = (op == OP_AND); isNotE = (op == OP_NOT); isMovE = (op == OP_MOV);
        isCmpE = (op == OP_CMP); isLdE = (op == OP_LD); isStE = (op == OP_ST);
        isCallE = (op == OP_CALL); isBeqE = (op == OP_BEQ); isBgtE = (op == OP_BGT);
        isRetE = (op == OP_RET);
        isUbranchE = (op == OP_UB) || (op == OP_RET) || (op == OP_CALL);
    endtask

    task automatic drive_bubble();
        validE = 1'b0;
        set_ctrl(OP_NOP);
        isImmediateE = 1'b0;
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_imm, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] tgt);
        logic [31:0] bb, e_alu, e_bpc;
        logic        e_taken;
        logic [5:0]  e_stall;
        bit          done;
        @(posedge clk);
        #1;
        validE = 1'b1;
        set_ctrl(op);
        op1E = a; op2E = b; immxE = imm; isImmediateE = use_imm;
        PCE = pc; branchTargetE = tgt;
        bb      = use_imm ? imm : b;
        e_alu   = ref_alu(op, a, bb, pc);
        e_taken = (op == OP_UB) || (op == OP_RET) || (op == OP_CALL) ||
                  (op == OP_BEQ && m_fe) || (op == OP_BGT && m_fg);
        e_bpc   = (op == OP_RET) ? a : tgt;
        e_stall = (op == OP_DIV || op == OP_MOD) ? 6'd33 : 6'd0;
        exp_q.push_back({e_stall, m_fe, m_fg, e_taken, e_bpc, e_alu});
        if (op == OP_CMP) begin
            m_fe = (a == bb);
            m_fg = ($signed(a) > $signed(bb));
        end
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stallEx) begin
                done = 1;
                break;
            end
            // Operands after the capture edge must not influence the result.
            if (i >= 1) begin
                op1E = $urandom; op2E = $urandom; immxE = $urandom;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL stall_timeout: stallEx still 1 after 40 cycles, required release");
        end
    endtask

    task automatic junk_bubble();
        @(posedge clk);
        #1;
        drive_bubble();
        isDivE = 1'b1; isUbranchE = 1'b1; isCmpE = 1'b1;
        op1E = $urandom; op2E = $urandom;
        @(negedge clk);
        check32("bubble_stall", {31'd0, stallEx}, 32'd0);
        check32("bubble_taken", {31'd0, isBranchTakenE}, 32'd0);
        @(posedge clk);
        #1;
        drive_bubble();
    endtask

    // Monitor: every non-stalled valid cycle retires one instruction.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
            end else if (stallEx) begin
                stall_cnt++;
            end else if (validE) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_retire: got alu %h with empty queue, required none", aluResultE);
                end else begin
                    e = exp_q.pop_front();
                    check32("alu_result", aluResultE, e[31:0]);
                    check32("branch_pc", branchPCE, e[63:32]);
                    check32("branch_taken", {31'd0, isBranchTakenE}, {31'd0, e[64]});
                    check32("flags", {30'd0, flagE, flagGT}, {30'd0, e[66], e[65]});
                    check32("stall_cycles", stall_cnt, {26'd0, e[72:67]});
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        reset = 1'b1;
        drive_bubble();
        PCE = 32'h100; branchTargetE = 32'h200; immxE = 32'd0;
        op1E = 32'd3; op2E = 32'd4;
        @(posedge clk);
        #1;
        validE = 1'b1; set_ctrl(OP_DIV);
        @(negedge clk);
        check32("reset_stall", {31'd0, stallEx}, 32'd0);
        check32("reset_flags", {30'd0, flagE, flagGT}, 32'd0);
        set_ctrl(OP_ADD);
        #1;
        check32("reset_comb_alu", aluResultE, 32'd7);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_bubble();

        issue(OP_ADD, 32'd7, 32'd99, 1'b1, 32'd5, 32'h0, 32'h0);
        issue(OP_CMP, 32'hFFFF_FFFD, 32'd2, 1'b0, 32'd0, 32'h10, 32'h80);
        issue(OP_BEQ, 32'd0, 32'd0, 1'b0, 32'd0, 32'h14, 32'h80);
        issue(OP_BGT, 32'd0, 32'd0, 1'b0, 32'd0, 32'h18, 32'h84);
        issue(OP_CMP, 32'd5, 32'd5, 1'b0, 32'd0, 32'h1C, 32'h0);
        issue(OP_BEQ, 32'd0, 32'd0, 1'b0, 32'd0, 32'h20, 32'h40);
        issue(OP_RET, 32'h1234, 32'd0, 1'b0, 32'd0, 32'h24, 32'h40);
        issue(OP_CALL, 32'd0, 32'd0, 1'b0, 32'd0, 32'h28, 32'h300);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_MOD, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_DIV, 32'd9, 32'd0, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_MOD, 32'd9, 32'd0, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_DIV, 32'd100, 32'd7, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_MOD, 32'd100, 32'd7, 1'b0, 32'd0, 32'h0, 32'h0);
        issue(OP_CMP, 32'd5, 32'd5, 1'b0, 32'd0, 32'h0, 32'h0);

        // Abort a division with reset ten cycles in.
        @(posedge clk);
        #1;
        validE = 1'b1; set_ctrl(OP_DIV);
        op1E = 32'd100; op2E = 32'd3; isImmediateE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check32("stall_during_reset", {31'd0, stallEx}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_bubble();
        m_fe = 1'b0;
        m_fg = 1'b0;
        @(negedge clk);
        check32("stall_after_reset", {31'd0, stallEx}, 32'd0);
        check32("flags_after_reset", {30'd0, flagE, flagGT}, 32'd0);
        issue(OP_ADD, 32'd1, 32'd1, 1'b0, 32'd0, 32'h0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                junk_bubble();
            end else begin
                op = $urandom_range(0, NUM_OPS - 1);
                if ((op == OP_DIV || op == OP_MOD) && $urandom_range(0, 3) != 0) op = OP_SUB;
                if ($urandom_range(0, 1) == 0)
                    issue(op, $urandom, $urandom, $urandom_range(0, 1), $urandom,
                          $urandom, $urandom);
                else
                    issue(op, $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10,
                          $urandom_range(0, 1), $urandom_range(0, 20) - 10,
                          $urandom, $urandom);
            end
        end

        @(posedge clk);
        #1;
        drive_bubble();
        repeat (3) @(posedge clk);
        check32("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
